hack_cpu_mc: RTL and testbench
==============================

HACK_CPU_MC -- requirements
Module: hack_cpu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning datapath/instruction width (min 8).
REQ-002 SHALL have parameter PC_W, default WIDTH-1, meaning program counter and data address width.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n  in  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr  out  PC_W  meaning instruction fetch address, equal to pc.
REQ-006 SHALL have port imem_data  in  WIDTH  meaning fetched instruction word.
REQ-007 SHALL have port imem_valid  in  1  meaning imem_data is valid this cycle.
REQ-008 SHALL have port dmem_req  out  1  meaning data memory access request.
REQ-009 SHALL have port dmem_we  out  1  meaning 1 for write, 0 for read; valid only while dmem_req=1.
REQ-010 SHALL have port dmem_addr  out  PC_W  meaning data address, equal to A[PC_W-1:0].
REQ-011 SHALL have port dmem_wdata  out  WIDTH  meaning registered ALU result to write.
REQ-012 SHALL have port dmem_rdata  in  WIDTH  meaning read data, sampled on the dmem_ack cycle.
REQ-013 SHALL have port dmem_ack  in  1  meaning the access completes this cycle.
REQ-014 SHALL have port pc  out  PC_W  meaning current program counter.
REQ-015 SHALL have port retire  out  1  meaning one-cycle pulse per committed instruction.
REQ-016 SHALL have port halted  out  1  meaning sticky halt flag.

Function
REQ-017 SHALL implement FSM states FETCH, MEM_RD, EXEC, MEM_WR, HALT.
REQ-018 FETCH: when imem_valid=1, SHALL latch IR<=imem_data; C-instr (IR[WIDTH-1]=1) with a-bit (bit WIDTH-4) set -> MEM_RD, otherwise -> EXEC; imem_valid=0 holds FETCH indefinitely.
REQ-019 MEM_RD: SHALL hold dmem_req=1, dmem_we=0 until dmem_ack; on ack SHALL latch M_r<=dmem_rdata and go to EXEC.
REQ-020 EXEC, A-instr: SHALL commit A<=zero-extended IR[WIDTH-2:0], pc<=pc+1.
REQ-021 EXEC, C-instr: SHALL compute ALU(x=D, y=a?M_r:A) using the six Hack control bits; if d3 (writeM) set, SHALL register the result into wdata_r and go to MEM_WR, otherwise commit.
REQ-022 MEM_WR: SHALL hold dmem_req=1, dmem_we=1, dmem_addr=pre-commit A until dmem_ack; on ack SHALL commit.
REQ-023 Commit SHALL update, in one edge, A (if d1), D (if d2), pc (jump target A[PC_W-1:0] pre-commit if taken, else pc+1 modulo 2^PC_W), pulse retire, return to FETCH.
REQ-024 Jump taken SHALL be j1&ng | j2&zr | j3&~ng&~zr, giving all eight Hack jump codes (000 never, 111 always).
REQ-025 Arithmetic SHALL be WIDTH bits, two's-complement, carry discarded; ng = result MSB, zr = result all-zero.
REQ-026 An always-taken jump (j=111) whose target equals current pc SHALL commit, then set halted=1 and enter HALT; HALT SHALL issue no fetch or memory request until reset.
REQ-027 dmem_req SHALL be 0 in FETCH, EXEC, HALT; dmem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-028 Minimum latency: 2 cycles (A-instr, or C-instr without memory), 3 cycles with read or write, 4 cycles with both, plus wait states.

Reset
REQ-029 rst_n=0 SHALL asynchronously force A=0, D=0, pc=0, IR=0, M_r=0, wdata_r=0, state=FETCH, halted=0, retire=0, dmem_req=0, dmem_we=0.
REQ-030 Reset asserted mid-access SHALL abandon the access without commit; after release, fetch SHALL restart at pc=0.

Structure
REQ-031 A shared package hack_pkg SHALL hold the state enum, field bit-position constants and jump-code constants.
REQ-032 The ALU SHALL be a separate combinational sub-module hack_alu #(WIDTH).

Verification
REQ-033 @5; D=A; @7; D=D+A -> D=12 after 4 retires, dmem_req never asserted.
REQ-034 @100; M=-1 with dmem_ack delayed 3 cycles -> dmem_addr=100, dmem_wdata=16'hFFFF, we=1 held 3 cycles, retire once after ack.
REQ-035 @100; D=M+1 with dmem_rdata=41 -> D=42; read then no write; 3-cycle min latency.
REQ-036 D=-1 then @20; D;JLT taken -> pc=20; D=0; D;JGT -> pc increments.
REQ-037 @3 at pc=2..3 forming 0;JMP to self -> halted=1, no further imem/dmem activity; rst_n low in MEM_WR -> no write commit, pc=0.
REQ-038 WIDTH=24, PC_W=23: pc at 2^23-1 non-jump -> wraps to 0.

Source files
------------

// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared types and instruction field constants for the Hack multi-cycle CPU
package hack_pkg;

  // Sequencer states of the multi-cycle core
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_MEM_RD = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // The a-bit sits a fixed distance below the instruction MSB; the rest of the
  // C-instruction fields keep their Hack positions at the bottom of the word.
  localparam int A_BIT_FROM_MSB = 3;
  localparam int ZX_BIT = 11;
  localparam int NX_BIT = 10;
  localparam int ZY_BIT = 9;
  localparam int NY_BIT = 8;
  localparam int F_BIT  = 7;
  localparam int NO_BIT = 6;
  localparam int D1_BIT = 5;  // dest A
  localparam int D2_BIT = 4;  // dest D
  localparam int D3_BIT = 3;  // dest M
  localparam int J1_BIT = 2;
  localparam int J2_BIT = 1;
  localparam int J3_BIT = 0;

  // Hack jump codes
  localparam logic [2:0] JMP_NEVER  = 3'b000;
  localparam logic [2:0] JMP_JGT    = 3'b001;
  localparam logic [2:0] JMP_JEQ    = 3'b010;
  localparam logic [2:0] JMP_JGE    = 3'b011;
  localparam logic [2:0] JMP_JLT    = 3'b100;
  localparam logic [2:0] JMP_JNE    = 3'b101;
  localparam logic [2:0] JMP_JLE    = 3'b110;
  localparam logic [2:0] JMP_ALWAYS = 3'b111;

  // j1 fires on negative, j2 on zero, j3 on strictly positive
  function automatic logic jump_taken(input logic [2:0] j, input logic ng, input logic zr);
    return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_alu.sv
// rtl/hack_alu.sv - combinational Hack ALU with zero/negative flags
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             zx_i,
  input  logic             nx_i,
  input  logic             zy_i,
  input  logic             ny_i,
  input  logic             f_i,
  input  logic             no_i,
  output logic [WIDTH-1:0] out_o,
  output logic             zr_o,
  output logic             ng_o
);

  logic [WIDTH-1:0] x_z, x_n, y_z, y_n, r;

  // Zero/negate each operand, add or AND, optionally negate, then derive flags
  always_comb begin
    x_z   = zx_i ? '0 : x_i;
    x_n   = nx_i ? ~x_z : x_z;
    y_z   = zy_i ? '0 : y_i;
    y_n   = ny_i ? ~y_z : y_z;
    r     = f_i ? (x_n + y_n) : (x_n & y_n);
    out_o = no_i ? ~r : r;
    zr_o  = (out_o == '0);
    ng_o  = out_o[WIDTH-1];
  end

endmodule

// File: rtl/hack_cpu_mc.sv
// rtl/hack_cpu_mc.sv - multi-cycle Hack CPU with handshaked instruction and data memories
module hack_cpu_mc
  import hack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PC_W  = WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             imem_valid,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [PC_W-1:0]  dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic [PC_W-1:0]  pc,
  output logic             retire,
  output logic             halted
);

  localparam int A_BIT = WIDTH - 1 - A_BIT_FROM_MSB;
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] dreg_q, dreg_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             halted_q, halted_d;
  logic             retire_q, retire_d;

  logic [WIDTH-1:0] alu_out;
  logic             alu_zr, alu_ng;
  logic             do_commit;

  // ALU operands stay stable from EXEC through MEM_WR (A, D and M_r only change
  // at commit), so its result and flags are still valid when a write completes.
  hack_alu #(.WIDTH(WIDTH)) u_alu (
    .x_i  (dreg_q),
    .y_i  (ir_q[A_BIT] ? mr_q : a_q),
    .zx_i (ir_q[ZX_BIT]),
    .nx_i (ir_q[NX_BIT]),
    .zy_i (ir_q[ZY_BIT]),
    .ny_i (ir_q[NY_BIT]),
    .f_i  (ir_q[F_BIT]),
    .no_i (ir_q[NO_BIT]),
    .out_o(alu_out),
    .zr_o (alu_zr),
    .ng_o (alu_ng)
  );

  // Next-state sequencing and architectural register updates
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    dreg_d    = dreg_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mr_d      = mr_q;
    wdata_d   = wdata_q;
    halted_d  = halted_q;
    retire_d  = 1'b0;
    do_commit = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = (imem_data[WIDTH-1] && imem_data[A_BIT]) ? ST_MEM_RD : ST_EXEC;
        end
      end
      ST_MEM_RD: begin
        if (dmem_ack) begin
          mr_d    = dmem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!ir_q[WIDTH-1]) begin
          a_d      = {1'b0, ir_q[WIDTH-2:0]};
          pc_d     = pc_q + PC_ONE;
          retire_d = 1'b1;
          state_d  = ST_FETCH;
        end else if (ir_q[D3_BIT]) begin
          wdata_d = alu_out;
          state_d = ST_MEM_WR;
        end else begin
          do_commit = 1'b1;
        end
      end
      ST_MEM_WR: begin
        if (dmem_ack) do_commit = 1'b1;
      end
      default: ;  // ST_HALT: frozen until reset
    endcase

    if (do_commit) begin
      if (ir_q[D1_BIT]) a_d = alu_out;
      if (ir_q[D2_BIT]) dreg_d = alu_out;
      pc_d     = jump_taken(ir_q[2:0], alu_ng, alu_zr) ? a_q[PC_W-1:0] : pc_q + PC_ONE;
      retire_d = 1'b1;
      // An unconditional jump to itself can never make progress: park the core
      if (ir_q[2:0] == JMP_ALWAYS && a_q[PC_W-1:0] == pc_q) begin
        halted_d = 1'b1;
        state_d  = ST_HALT;
      end else begin
        state_d = ST_FETCH;
      end
    end
  end

  // State register with asynchronous clear; an access in flight is simply dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      a_q      <= '0;
      dreg_q   <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      mr_q     <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      dreg_q   <= dreg_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mr_q     <= mr_d;
      wdata_q  <= wdata_d;
      halted_q <= halted_d;
      retire_q <= retire_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign retire     = retire_q;
  assign halted     = halted_q;
  assign dmem_req   = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
  assign dmem_we    = (state_q == ST_MEM_WR);
  assign dmem_addr  = a_q[PC_W-1:0];
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// tb/tb_hack_cpu_mc.sv - directed self-checking bench for hack_cpu_mc
module tb_hack_cpu_mc;

  logic        clk;
  logic        rst_n;
  logic [14:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        dmem_req, dmem_we;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [14:0] pc;
  logic        retire, halted;

  logic        w_rst_n;
  logic [22:0] w_imem_addr;
  logic [23:0] w_imem_data;
  logic        w_imem_valid;
  logic        w_dmem_req, w_dmem_we;
  logic [22:0] w_dmem_addr;
  logic [23:0] w_dmem_wdata, w_dmem_rdata;
  logic        w_dmem_ack;
  logic [22:0] w_pc;
  logic        w_retire, w_halted;

  int checks;
  int failures;

  logic [15:0] imem_mem [0:31];
  logic [15:0] dmem_mem [0:127];

  int          tick_n, retires, req_total, rd_cycles, wr_cycles, writes, req_run, ack_hold;
  int          rt_tick [0:15];
  logic [14:0] rt_pc   [0:15];
  logic [14:0] last_wr_addr;
  logic [15:0] last_wr_data;

  int          w_ret;
  logic [22:0] w_pcs [0:3];

  hack_cpu_mc #(.WIDTH(16), .PC_W(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .retire(retire), .halted(halted)
  );

  hack_cpu_mc #(.WIDTH(24), .PC_W(23)) dut_w (
    .clk(clk), .rst_n(w_rst_n),
    .imem_addr(w_imem_addr), .imem_data(w_imem_data), .imem_valid(w_imem_valid),
    .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_addr(w_dmem_addr),
    .dmem_wdata(w_dmem_wdata), .dmem_rdata(w_dmem_rdata), .dmem_ack(w_dmem_ack),
    .pc(w_pc), .retire(w_retire), .halted(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = imem_mem[imem_addr[4:0]];

  // wide core program: @max; 0;JMP -> pc=max; @5 at max -> wraps to 0
  always_comb begin
    w_imem_data = 24'h000000;
    if (w_imem_addr == 23'd0)             w_imem_data = 24'h7FFFFF;
    else if (w_imem_addr == 23'd1)        w_imem_data = 24'hE00A87;
    else if (w_imem_addr == 23'h7FFFFF)   w_imem_data = 24'h000005;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem_mem[i] = 16'h0000;
  endtask

  task automatic start();
    @(negedge clk);
    rst_n     = 1'b0;
    dmem_ack  = 1'b0;
    tick_n    = 0;
    retires   = 0;
    req_total = 0;
    rd_cycles = 0;
    wr_cycles = 0;
    writes    = 0;
    req_run   = 0;
    last_wr_addr = '0;
    last_wr_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one clock; sample 1ns after the edge, then model data memory for the next cycle
  task automatic tick();
    @(posedge clk);
    #1;
    tick_n++;
    if (retire) begin
      if (retires < 16) begin
        rt_tick[retires] = tick_n;
        rt_pc[retires]   = pc;
      end
      retires++;
    end
    if (dmem_req) begin
      req_total++;
      if (dmem_we) wr_cycles++;
      else rd_cycles++;
      req_run++;
      dmem_ack = (ack_hold != 0) && (req_run == ack_hold);
      if (dmem_ack && dmem_we) begin
        writes++;
        last_wr_addr = dmem_addr;
        last_wr_data = dmem_wdata;
        dmem_mem[dmem_addr[6:0]] = dmem_wdata;
      end
    end else begin
      req_run  = 0;
      dmem_ack = 1'b0;
    end
    dmem_rdata = dmem_mem[dmem_addr[6:0]];
  endtask

  task automatic run_retires(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && retires < n; i++) tick();
    check(tag, 32'(retires >= n), 32'd1);
  endtask

  task automatic run_halt(input string tag, input int budget);
    for (int i = 0; i < budget && !halted; i++) tick();
    check(tag, 32'(halted), 32'd1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    w_rst_n = 1'b0;
    imem_valid = 1'b1;
    w_imem_valid = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    w_dmem_ack = 1'b0;
    w_dmem_rdata = '0;
    ack_hold = 1;
    clear_imem();
    for (int i = 0; i < 128; i++) dmem_mem[i] = 16'h0000;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_wdata", 32'(dmem_wdata), 32'd0);
    check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    check("rst_w_pc", 32'(w_pc), 32'd0);

    // @5; D=A; @7; D=D+A; @30; M=D; halt
    clear_imem();
    imem_mem[0] = 16'h0005; imem_mem[1] = 16'hEC10;
    imem_mem[2] = 16'h0007; imem_mem[3] = 16'hE090;
    imem_mem[4] = 16'h001E; imem_mem[5] = 16'hE308;
    imem_mem[6] = 16'h0007; imem_mem[7] = 16'hEA87;
    ack_hold = 1;
    start();
    run_retires("s1_budget4", 4, 40);
    check("s1_tick_of_4th_retire", 32'(rt_tick[3]), 32'd8);
    check("s1_no_req", 32'(req_total), 32'd0);
    run_halt("s1_halt", 60);
    check("s1_wr_addr", 32'(last_wr_addr), 32'd30);
    check("s1_D_eq_12", 32'(last_wr_data), 32'd12);
    check("s1_halt_pc", 32'(pc), 32'd7);
    check("s1_retires", 32'(retires), 32'd8);

    // @100; M=-1 with ack on the third write cycle
    clear_imem();
    imem_mem[0] = 16'h0064; imem_mem[1] = 16'hEE88;
    imem_mem[2] = 16'h0003; imem_mem[3] = 16'hEA87;
    ack_hold = 3;
    start();
    run_halt("s2_halt", 60);
    check("s2_we_cycles", 32'(wr_cycles), 32'd3);
    check("s2_wr_addr", 32'(last_wr_addr), 32'd100);
    check("s2_wr_data", 32'(last_wr_data), 32'h0000FFFF);
    check("s2_writes", 32'(writes), 32'd1);
    check("s2_retire_tick", 32'(rt_tick[1]), 32'd7);
    check("s2_retires", 32'(retires), 32'd4);

    // @100; D=M+1 with M=41; @30; M=D
    clear_imem();
    dmem_mem[100] = 16'd41;
    imem_mem[0] = 16'h0064; imem_mem[1] = 16'hFDD0;
    imem_mem[2] = 16'h001E; imem_mem[3] = 16'hE308;
    imem_mem[4] = 16'h0005; imem_mem[5] = 16'hEA87;
    ack_hold = 1;
    start();
    run_halt("s3_halt", 60);
    check("s3_read_latency", 32'(rt_tick[1]), 32'd5);
    check("s3_rd_cycles", 32'(rd_cycles), 32'd1);
    check("s3_wr_cycles", 32'(wr_cycles), 32'd1);
    check("s3_wr_addr", 32'(last_wr_addr), 32'd30);
    check("s3_D_eq_42", 32'(last_wr_data), 32'd42);

    // D=-1; @20; D;JLT (taken) ; D=0; @30; D;JGT (not taken); halt at 24
    clear_imem();
    imem_mem[0]  = 16'hEE90; imem_mem[1]  = 16'h0014; imem_mem[2]  = 16'hE304;
    imem_mem[20] = 16'hEA90; imem_mem[21] = 16'h001E; imem_mem[22] = 16'hE301;
    imem_mem[23] = 16'h0018; imem_mem[24] = 16'hEA87;
    start();
    run_halt("s4_halt", 80);
    check("s4_jlt_taken_pc", 32'(rt_pc[2]), 32'd20);
    check("s4_jgt_not_taken_pc", 32'(rt_pc[5]), 32'd23);
    check("s4_halt_pc", 32'(pc), 32'd24);
    check("s4_no_req", 32'(req_total), 32'd0);

    // imem stall, then @3 at pc=2 and 0;JMP at pc=3 halts
    clear_imem();
    imem_mem[2] = 16'h0003; imem_mem[3] = 16'hEA87;
    imem_valid = 1'b0;
    start();
    repeat (5) tick();
    check("s5_stall_retires", 32'(retires), 32'd0);
    check("s5_stall_pc", 32'(pc), 32'd0);
    imem_valid = 1'b1;
    run_halt("s5_halt", 40);
    check("s5_halt_pc", 32'(pc), 32'd3);
    repeat (6) tick();
    check("s5_quiet_retires", 32'(retires), 32'd4);
    check("s5_quiet_req", 32'(req_total), 32'd0);
    check("s5_quiet_imem_addr", 32'(imem_addr), 32'd3);

    // reset in the middle of a write that never gets acked
    clear_imem();
    imem_mem[0] = 16'h0064; imem_mem[1] = 16'hEE88;
    imem_mem[2] = 16'h0003; imem_mem[3] = 16'hEA87;
    ack_hold = 0;
    start();
    for (int i = 0; i < 20 && wr_cycles < 2; i++) tick();
    check("s6_in_write", 32'(dmem_we), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_async_req", 32'(dmem_req), 32'd0);
    check("s6_async_we", 32'(dmem_we), 32'd0);
    check("s6_async_pc", 32'(pc), 32'd0);
    check("s6_no_write", 32'(writes), 32'd0);
    @(negedge clk);
    tick_n = 0; retires = 0; req_total = 0; rd_cycles = 0; wr_cycles = 0;
    writes = 0; req_run = 0; dmem_ack = 1'b0; ack_hold = 1;
    rst_n = 1'b1;
    check("s6_restart_addr", 32'(imem_addr), 32'd0);
    run_halt("s6_halt", 40);
    check("s6_first_retire_pc", 32'(rt_pc[0]), 32'd1);
    check("s6_writes_after", 32'(writes), 32'd1);

    // 24-bit core: pc 2^23-1 with a non-jump wraps to 0
    w_ret = 0;
    @(negedge clk);
    w_rst_n = 1'b1;
    for (int i = 0; i < 30 && w_ret < 3; i++) begin
      @(posedge clk);
      #1;
      if (w_retire) begin
        w_pcs[w_ret] = w_pc;
        w_ret++;
      end
    end
    check("s7_budget", 32'(w_ret >= 3), 32'd1);
    check("s7_pc_after_at", 32'(w_pcs[0]), 32'd1);
    check("s7_pc_after_jmp", 32'(w_pcs[1]), 32'h007FFFFF);
    check("s7_pc_wrap", 32'(w_pcs[2]), 32'd0);
    check("s7_no_req", 32'(w_dmem_req), 32'd0);
    check("s7_no_we", 32'(w_dmem_we), 32'd0);
    check("s7_not_halted", 32'(w_halted), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
